intdiv_seq: RTL

INTDIV_SEQ -- requirements
Module: intdiv_seq

---
 rtl/mdu_pkg.sv | 16 +
 rtl/divstep.sv | 17 +
 rtl/intdiv_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: Funct3 op encodings and
// the divider state type.
package mdu_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divstep.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor, subtract when it fits, and report the resulting quotient bit.
module divstep #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   i_rem,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  // When the subtraction succeeds the difference is below the divisor,
  // so the low XLEN bits carry the exact result.
  assign o_qbit = (i_rem >= {1'b0, i_divisor});
  assign o_rem  = o_qbit ? (i_rem[XLEN-1:0] - i_divisor) : i_rem[XLEN-1:0];

endmodule

// File: rtl/intdiv_seq.sv
// Sequential restoring integer divider (DIV/DIVU/REM/REMU), one quotient bit
// per cycle, with sign handling, divide-by-zero and overflow selection.
module intdiv_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [XLEN-1:0] ForwardedSrcAE,
  input  logic [XLEN-1:0] ForwardedSrcBE,
  input  logic [2:0]      Funct3E,
  output logic            Busy,
  output logic            DoneM,
  output logic [XLEN-1:0] ResultM
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  div_state_t r_state, w_state_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quot, r_divisor, r_a, r_result;
  logic            r_is_rem, r_neg_q, r_neg_r, r_div0, r_ovf;

  logic            w_signed, w_is_rem, w_a_neg, w_b_neg, w_start;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic [XLEN-1:0] w_step_rem, w_quot_next;
  logic            w_step_q;
  logic [XLEN-1:0] w_q_final, w_r_final, w_result;

  assign w_signed = (Funct3E == F3_DIV) || (Funct3E == F3_REM);
  assign w_is_rem = (Funct3E == F3_REM) || (Funct3E == F3_REMU);
  assign w_a_neg  = w_signed & ForwardedSrcAE[XLEN-1];
  assign w_b_neg  = w_signed & ForwardedSrcBE[XLEN-1];
  assign w_a_abs  = w_a_neg ? -ForwardedSrcAE : ForwardedSrcAE;
  assign w_b_abs  = w_b_neg ? -ForwardedSrcBE : ForwardedSrcBE;
  assign w_start  = (r_state == IDLE) & StartE & ~FlushE;

  divstep #(.XLEN(XLEN)) u_step (
    .i_rem     ({r_rem, r_quot[XLEN-1]}),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  assign w_quot_next = {r_quot[XLEN-2:0], w_step_q};

  // Final-step values are post-processed in the same cycle they are produced,
  // so ResultM is already valid when DONE is entered.
  always_comb begin
    w_q_final = r_neg_q ? -w_quot_next : w_quot_next;
    w_r_final = r_neg_r ? -w_step_rem : w_step_rem;
    if (r_div0) begin
      w_q_final = ALL_ONES;
      w_r_final = r_a;
    end else if (r_ovf) begin
      w_q_final = MIN_NEG;
      w_r_final = '0;
    end
    w_result = r_is_rem ? w_r_final : w_q_final;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (StartE) w_state_next = ITER;
      ITER:    if (r_cnt == '0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (FlushE) w_state_next = IDLE;
    Busy  = (r_state != IDLE);
    DoneM = (r_state == DONE) & ~FlushE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_a       <= '0;
      r_result  <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_start) begin
      r_cnt     <= CW'(XLEN-1);
      r_rem     <= '0;
      r_quot    <= w_a_abs;
      r_divisor <= w_b_abs;
      r_a       <= ForwardedSrcAE;
      r_is_rem  <= w_is_rem;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_div0    <= (ForwardedSrcBE == '0);
      r_ovf     <= w_signed & (ForwardedSrcAE == MIN_NEG) & (ForwardedSrcBE == ALL_ONES);
    end else if (r_state == ITER) begin
      r_rem  <= w_step_rem;
      r_quot <= w_quot_next;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if ((r_cnt == '0) && !FlushE) r_result <= w_result;
    end
  end

  assign ResultM = r_result;

endmodule
